alu_issue_ctrl: RTL and testbench

Initiator/controller side of the 16-bit combinational ALU interface (operands N/M, 3-bit opcode, carry-in; result F with zero/negative flags). Accepts encoded instructions over a valid/ready handshake, reads operands from a small register file, and drives the external ALU. It samples the ALU result and flags, then writes back to the register file and a flag register. Supports conditional execution based on the stored flags, so simple programs can run on the ALU without a CPU.

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, condition codes,
// instruction field layout, FSM encoding and small decode helpers.
package alu_pkg;

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SHRADD = 3'd1;
   localparam logic [2:0] OP_MAX    = 3'd2;
   localparam logic [2:0] OP_MUL3   = 3'd3;
   localparam logic [2:0] OP_AND    = 3'd4;
   localparam logic [2:0] OP_OR     = 3'd5;
   localparam logic [2:0] OP_NOT    = 3'd6;
   localparam logic [2:0] OP_ZERO   = 3'd7;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_N      = 2'b10;
   localparam logic [1:0] COND_NZ     = 2'b11;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned RIDX_W   = 2;
   localparam int unsigned OPC_LSB  = 13;
   localparam int unsigned RD_LSB   = 11;
   localparam int unsigned RS_LSB   = 9;
   localparam int unsigned RT_LSB   = 7;
   localparam int unsigned CIN_BIT  = 6;
   localparam int unsigned COND_LSB = 4;

   typedef enum logic {
      StIdle = 1'b0,
      StExec = 1'b1
   } state_e;

   typedef struct packed {
      logic [2:0]        opc;
      logic [RIDX_W-1:0] rd;
      logic [RIDX_W-1:0] rs;
      logic [RIDX_W-1:0] rt;
      logic              cin;
      logic [1:0]        cond;
   } instr_t;

   // Reserved low bits of the raw instruction are dropped here.
   function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
      instr_t d;
      d.opc  = raw[OPC_LSB +: 3];
      d.rd   = raw[RD_LSB +: RIDX_W];
      d.rs   = raw[RS_LSB +: RIDX_W];
      d.rt   = raw[RT_LSB +: RIDX_W];
      d.cin  = raw[CIN_BIT];
      d.cond = raw[COND_LSB +: 2];
      return d;
   endfunction

   function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic n);
      logic met;
      unique case (cond)
         COND_ALWAYS: met = 1'b1;
         COND_Z:      met = z;
         COND_N:      met = n;
         COND_NZ:     met = ~z;
         default:     met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: two operand read ports, a debug read port and a
// single write port where instruction writeback overrides a direct load.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned DW   = 16,
   parameter int unsigned NREG = 4,
   parameter int unsigned AW   = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] ra_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] ra_b,
   output logic [DW-1:0] rdata_b,
   input  logic [AW-1:0] ra_dbg,
   output logic [DW-1:0] rdata_dbg,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];

   // Writeback is applied last so it wins a same-register collision.
   always_comb begin
      regs_d = regs_q;
      if (ld_en) begin
         regs_d[ld_addr] = ld_data;
      end
      if (wb_en) begin
         regs_d[wb_addr] = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a   = regs_q[ra_a];
   assign rdata_b   = regs_q[ra_b];
   assign rdata_dbg = regs_q[ra_dbg];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external combinational ALU: accepts instructions,
// drives operands from the register file and retires results with flags.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned DW   = 16,
   parameter int unsigned NREG = 4,
   parameter int unsigned AW   = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               ld_en,
   input  logic [AW-1:0]      ld_addr,
   input  logic [DW-1:0]      ld_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [DW-1:0]      rd_data,
   output logic [DW-1:0]      alu_n,
   output logic [DW-1:0]      alu_m,
   output logic [2:0]         alu_opc,
   output logic               alu_cin,
   input  logic [DW-1:0]      alu_f,
   input  logic               alu_zer,
   input  logic               alu_neg,
   output logic               done,
   output logic               skipped,
   output logic [DW-1:0]      res,
   output logic               flag_z,
   output logic               flag_n
);

   state_e        state_q, state_d;
   instr_t        instr_q, instr_d;
   logic [DW-1:0] res_q, res_d;
   logic          flag_z_q, flag_z_d;
   logic          flag_n_q, flag_n_d;
   logic          done_q, done_d;
   logic          skipped_q, skipped_d;
   logic          wb_en;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      res_d     = res_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      done_d    = 1'b0;
      skipped_d = 1'b0;
      wb_en     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               instr_d = decode_instr(in_instr);
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StIdle;
            done_d  = 1'b1;
            // Flags seen here belong to the previously retired instruction.
            if (cond_met(instr_q.cond, flag_z_q, flag_n_q)) begin
               wb_en    = 1'b1;
               res_d    = alu_f;
               flag_z_d = alu_zer;
               flag_n_d = alu_neg;
            end else begin
               skipped_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= StIdle;
         instr_q   <= '0;
         res_q     <= '0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         done_q    <= 1'b0;
         skipped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         res_q     <= res_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
         done_q    <= done_d;
         skipped_q <= skipped_d;
      end
   end

   alu_regfile #(
      .DW   (DW),
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk       (clk),
      .rstn      (rstn),
      .ra_a      (AW'(instr_q.rs)),
      .rdata_a   (alu_n),
      .ra_b      (AW'(instr_q.rt)),
      .rdata_b   (alu_m),
      .ra_dbg    (rd_addr),
      .rdata_dbg (rd_data),
      .wb_en     (wb_en),
      .wb_addr   (AW'(instr_q.rd)),
      .wb_data   (alu_f),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   assign in_ready = (state_q == StIdle);
   assign alu_opc  = instr_q.opc;
   assign alu_cin  = instr_q.cin;
   assign done     = done_q;
   assign skipped  = skipped_q;
   assign res      = res_q;
   assign flag_z   = flag_z_q;
   assign flag_n   = flag_n_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 16-bit ALU attached
// and a register/flag reference model updated per retired instruction.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        ld_en;
   logic [1:0]  ld_addr;
   logic [15:0] ld_data;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] alu_n, alu_m, alu_f;
   logic [2:0]  alu_opc;
   logic        alu_cin, alu_zer, alu_neg;
   logic        done, skipped, flag_z, flag_n;
   logic [15:0] res;

   int checks = 0;
   int failures = 0;

   logic [15:0] m_r [4];
   logic        m_z, m_n;
   logic [15:0] m_res;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DW(16), .NREG(4), .AW(2)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .alu_n    (alu_n),
      .alu_m    (alu_m),
      .alu_opc  (alu_opc),
      .alu_cin  (alu_cin),
      .alu_f    (alu_f),
      .alu_zer  (alu_zer),
      .alu_neg  (alu_neg),
      .done     (done),
      .skipped  (skipped),
      .res      (res),
      .flag_z   (flag_z),
      .flag_n   (flag_n)
   );

   // Behavioural stand-in for the external 16-bit ALU.
   function automatic logic [15:0] alu_fn(input logic [2:0] opc, input logic [15:0] n,
                                          input logic [15:0] m, input logic cin);
      case (opc)
         3'd0:    return n + m + {15'd0, cin};
         3'd1:    return {n[15], n[15:1]} + m;
         3'd2:    return ($signed(n) > $signed(m)) ? n : m;
         3'd3:    return n + n + n;
         3'd4:    return n & m;
         3'd5:    return n | m;
         3'd6:    return ~m;
         default: return 16'h0000;
      endcase
   endfunction

   always_comb begin
      alu_f   = alu_fn(alu_opc, alu_n, alu_m, alu_cin);
      alu_zer = (alu_f == 16'h0000);
      alu_neg = alu_f[15];
   end

   function automatic logic [15:0] mk(input logic [2:0] opc, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt,
                                      input logic cin, input logic [1:0] cond);
      return {opc, rd, rs, rt, cin, cond, 4'b0000};
   endfunction

   function automatic logic cond_ok(input logic [1:0] cond);
      if (cond == 2'b00) return 1'b1;
      if (cond == 2'b01) return m_z;
      if (cond == 2'b10) return m_n;
      return !m_z;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
      m_z = 1'b0;
      m_n = 1'b0;
      m_res = 16'h0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; in_valid = 1'b0; in_instr = 16'h0;
      ld_en = 1'b0; ld_addr = 2'd0; ld_data = 16'h0; rd_addr = 2'd0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      model_clear();
   endtask

   task automatic load_reg(input logic [1:0] a, input logic [15:0] v);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      @(negedge clk);
      ld_en = 1'b0;
      m_r[a] = v;
   endtask

   // Issue one instruction, with optional loads on its accept and retire edges.
   task automatic run_instr(input string tag, input logic [15:0] ins,
                            input logic acc_ld, input logic [1:0] acc_a, input logic [15:0] acc_v,
                            input logic ret_ld, input logic [1:0] ret_a, input logic [15:0] ret_v);
      logic [15:0] n, m, f;
      logic ok;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL %s idle_ready got=%b want=1", tag, in_ready);
      end
      in_valid = 1'b1; in_instr = ins;
      ld_en = acc_ld; ld_addr = acc_a; ld_data = acc_v;
      @(negedge clk);
      in_valid = 1'b0; ld_en = 1'b0;
      if (acc_ld) m_r[acc_a] = acc_v;
      n = m_r[ins[10:9]];
      m = m_r[ins[8:7]];
      f = alu_fn(ins[15:13], n, m, ins[6]);
      checks++;
      if ({in_ready, done} !== 2'b00) begin
         failures++; $display("FAIL %s exec_ready_done got=%b%b want=00", tag, in_ready, done);
      end
      checks++;
      if ({alu_opc, alu_cin, alu_n, alu_m} !== {ins[15:13], ins[6], n, m}) begin
         failures++;
         $display("FAIL %s alu_drive got=%h/%b/%h/%h want=%h/%b/%h/%h", tag,
                  alu_opc, alu_cin, alu_n, alu_m, ins[15:13], ins[6], n, m);
      end
      ld_en = ret_ld; ld_addr = ret_a; ld_data = ret_v;
      @(negedge clk);
      ld_en = 1'b0;
      if (ret_ld) m_r[ret_a] = ret_v;
      ok = cond_ok(ins[5:4]);
      if (ok) begin
         m_r[ins[12:11]] = f; m_res = f; m_z = (f == 16'h0); m_n = f[15];
      end
      checks++;
      if ({done, skipped, in_ready} !== {1'b1, !ok, 1'b1}) begin
         failures++;
         $display("FAIL %s retire done/skipped/ready got=%b%b%b want=1%b1", tag,
                  done, skipped, in_ready, !ok);
      end
      checks++;
      if ({res, flag_z, flag_n} !== {m_res, m_z, m_n}) begin
         failures++;
         $display("FAIL %s res_flags got=%h z=%b n=%b want=%h z=%b n=%b", tag,
                  res, flag_z, flag_n, m_res, m_z, m_n);
      end
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); #1;
         checks++;
         if (rd_data !== m_r[i]) begin
            failures++; $display("FAIL %s R%0d got=%h want=%h", tag, i, rd_data, m_r[i]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({in_ready, done, skipped, flag_z, flag_n} !== 5'b10000) begin
         failures++;
         $display("FAIL reset ctrl got=%b%b%b%b%b want=10000", in_ready, done, skipped, flag_z, flag_n);
      end
      checks++;
      if ({res, alu_n, alu_m, alu_opc, alu_cin} !== 52'h0) begin
         failures++; $display("FAIL reset data got res=%h n=%h m=%h opc=%h cin=%b want=0",
                              res, alu_n, alu_m, alu_opc, alu_cin);
      end
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); #1;
         checks++;
         if (rd_data !== 16'h0) begin
            failures++; $display("FAIL reset R%0d got=%h want=0000", i, rd_data);
         end
      end
   endtask

   task automatic test_add();
      load_reg(2'd0, 16'd5);
      load_reg(2'd1, 16'd3);
      run_instr("add", mk(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 2'b00), 0, 0, 0, 0, 0, 0);
      rd_addr = 2'd2; #1;
      checks++;
      if ({rd_data, res, flag_z, flag_n, skipped} !== {16'd9, 16'd9, 3'b000}) begin
         failures++; $display("FAIL add_const got R2=%h res=%h z=%b n=%b skip=%b want 9/9/0/0/0",
                              rd_data, res, flag_z, flag_n, skipped);
      end
   endtask

   task automatic test_not_max();
      load_reg(2'd3, 16'h0000);
      run_instr("not", mk(3'd6, 2'd3, 2'd0, 2'd3, 1'b0, 2'b00), 0, 0, 0, 0, 0, 0);
      checks++;
      if ({res, flag_z, flag_n} !== {16'hFFFF, 2'b01}) begin
         failures++; $display("FAIL not_const got res=%h z=%b n=%b want ffff z=0 n=1",
                              res, flag_z, flag_n);
      end
      load_reg(2'd0, 16'h8000);
      load_reg(2'd1, 16'h0001);
      run_instr("max", mk(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 2'b00), 0, 0, 0, 0, 0, 0);
      rd_addr = 2'd2; #1;
      checks++;
      if (rd_data !== 16'h0001) begin
         failures++; $display("FAIL max_const got R2=%h want=0001", rd_data);
      end
   endtask

   task automatic test_cond();
      run_instr("zero", mk(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 2'b00), 0, 0, 0, 0, 0, 0);
      run_instr("cond_nz_skip", mk(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'b11), 0, 0, 0, 0, 0, 0);
      checks++;
      if ({flag_z, skipped} !== 2'b11) begin
         failures++; $display("FAIL cond_skip_const got z=%b skip=%b want 1/1", flag_z, skipped);
      end
      run_instr("cond_z_exec", mk(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'b01), 0, 0, 0, 0, 0, 0);
      run_instr("cond_n_skip", mk(3'd5, 2'd3, 2'd1, 2'd1, 1'b0, 2'b10), 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [3];
      logic [15:0] f;
      logic ok, rdy_prev;
      int idx = 0;
      int ndone = 0;
      load_reg(2'd0, 16'd2);
      load_reg(2'd1, 16'd5);
      prog[0] = mk(3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 2'b00);
      prog[1] = mk(3'd3, 2'd1, 2'd1, 2'd0, 1'b0, 2'b00);
      prog[2] = mk(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 2'b00);
      @(negedge clk);
      rdy_prev = in_ready;
      in_valid = 1'b1; in_instr = prog[0];
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (rdy_prev && in_valid) begin
            idx++;
            if (idx < 3) in_instr = prog[idx];
            else in_valid = 1'b0;
         end
         if (cyc < 6) begin
            checks++;
            if (in_ready !== ((cyc % 2) == 0)) begin
               failures++; $display("FAIL b2b ready cyc=%0d got=%b want=%b", cyc, in_ready,
                                    (cyc % 2) == 0);
            end
         end
         if (done === 1'b1) begin
            checks++;
            if (ndone >= 3) begin
               failures++; $display("FAIL b2b extra_done cyc=%0d got=%0d want=3", cyc, ndone + 1);
            end else begin
               f = alu_fn(prog[ndone][15:13], m_r[prog[ndone][10:9]], m_r[prog[ndone][8:7]],
                          prog[ndone][6]);
               ok = cond_ok(prog[ndone][5:4]);
               if (ok) begin
                  m_r[prog[ndone][12:11]] = f; m_res = f; m_z = (f == 16'h0); m_n = f[15];
               end
               if ({res, flag_z, flag_n, skipped} !== {m_res, m_z, m_n, !ok}) begin
                  failures++; $display("FAIL b2b retire%0d got res=%h z=%b n=%b want res=%h z=%b n=%b",
                                       ndone, res, flag_z, flag_n, m_res, m_z, m_n);
               end
            end
            ndone++;
         end
         rdy_prev = in_ready;
      end
      checks++;
      if (ndone != 3 || idx != 3) begin
         failures++; $display("FAIL b2b counts got done=%0d acc=%0d want=3/3", ndone, idx);
      end
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); #1;
         checks++;
         if (rd_data !== m_r[i]) begin
            failures++; $display("FAIL b2b R%0d got=%h want=%h", i, rd_data, m_r[i]);
         end
      end
   endtask

   task automatic test_load_collision();
      load_reg(2'd0, 16'h0010);
      load_reg(2'd1, 16'h0001);
      run_instr("wb_over_load", mk(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'b00), 0, 0, 0, 1, 2'd2, 16'h1234);
      rd_addr = 2'd2; #1;
      checks++;
      if (rd_data !== 16'h0011) begin
         failures++; $display("FAIL collision_const got R2=%h want=0011", rd_data);
      end
      run_instr("load_at_accept", mk(3'd0, 2'd3, 2'd0, 2'd1, 1'b0, 2'b00), 1, 2'd0, 16'h0100, 0, 0, 0);
      rd_addr = 2'd3; #1;
      checks++;
      if (rd_data !== 16'h0101) begin
         failures++; $display("FAIL accept_load_const got R3=%h want=0101", rd_data);
      end
   endtask

   task automatic test_reset_mid_exec();
      @(negedge clk);
      in_valid = 1'b1; in_instr = mk(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 2'b00);
      @(negedge clk);
      in_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      model_clear();
      checks++;
      if ({done, in_ready, res, flag_z, flag_n} !== {2'b01, 18'h0}) begin
         failures++; $display("FAIL rst_exec got done=%b rdy=%b res=%h z=%b n=%b want 0/1/0/0/0",
                              done, in_ready, res, flag_z, flag_n);
      end
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); #1;
         checks++;
         if (rd_data !== 16'h0) begin
            failures++; $display("FAIL rst_exec R%0d got=%h want=0000", i, rd_data);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL rst_exec late_done got=%b want=0", done);
      end
   endtask

   task automatic test_random();
      logic [15:0] ins;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) load_reg(2'($urandom_range(0, 3)), 16'($urandom));
         ins = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)))
               | 16'($urandom_range(0, 15));
         run_instr("random", ins,
                   1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom),
                   1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_not_max();
      test_cond();
      test_back_to_back();
      test_load_collision();
      test_reset_mid_exec();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
